// File: rtl/rom_loader_if.sv
// rom_loader_if: groups the loader's byte-stream, ROM write and CPU control
// signals into one bundle.
//   stream : in_valid, in_data (to loader), in_ready (from loader)
//   rom    : rom_we, rom_addr, rom_wdata (from loader)
//   cpu    : start_pc, go, done (from loader), halt (to loader)
//   status : error, word_count (from loader)
// Modports: slave = the loader, master = the stream source / CPU side.
interface rom_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_wdata;
  logic [31:0]       start_pc;
  logic              go;
  logic              halt;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  modport slave (
    input  in_valid, in_data, halt,
    output in_ready, rom_we, rom_addr, rom_wdata, start_pc, go, done, error,
           word_count
  );

  modport master (
    output in_valid, in_data, halt,
    input  in_ready, rom_we, rom_addr, rom_wdata, start_pc, go, done, error,
           word_count
  );
endinterface

// File: rtl/rom_loader.sv
// rom_loader: boots a CPU from a little-endian byte stream. The stream is a
// 4-byte start PC, a 4-byte word count N, then N 32-bit words that are written
// into the instruction ROM from address 0. After the last word the CPU is
// released (go) and the loader waits for halt.
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - rom_loader_if.slave (stream in, ROM write out, CPU control/status)
//
// state   | meaning
// HDR_PC  | collecting the 4 start-PC bytes
// HDR_LEN | collecting the 4 length bytes, then range-checking N
// LOAD    | collecting instruction words, one ROM write per word
// START   | one-cycle gap covering the final ROM write
// RUN     | CPU running (go=1), waiting for halt
// DONE    | CPU halted; sticky until reset
// ERR     | header length rejected; sticky until reset
module rom_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input logic          clk,
  input logic          reset,
  rom_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    HDR_PC, HDR_LEN, LOAD, START, RUN, DONE, ERR
  } state_t;

  state_t            r_state;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_asm;
  logic [ADDR_W:0]   r_len;

  logic              r_in_ready;
  logic              r_rom_we;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [31:0]       r_rom_wdata;
  logic [31:0]       r_start_pc;
  logic              r_go;
  logic              r_done;
  logic              r_error;
  logic [ADDR_W:0]   r_word_count;

  logic              w_accept;
  logic              w_last_byte;
  logic [31:0]       w_word;
  logic [ADDR_W:0]   w_count_nxt;

  assign w_accept    = bus.in_valid & r_in_ready;
  assign w_last_byte = w_accept && (r_byte_cnt == 2'd3);
  // Bytes shift in from the top, so after four of them the first byte
  // received sits in bits 7:0 (little-endian).
  assign w_word      = {bus.in_data, r_asm};
  assign w_count_nxt = r_word_count + {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= HDR_PC;
      r_byte_cnt   <= 2'd0;
      r_asm        <= '0;
      r_len        <= '0;
      r_in_ready   <= 1'b0;
      r_rom_we     <= 1'b0;
      r_rom_addr   <= '0;
      r_rom_wdata  <= '0;
      r_start_pc   <= '0;
      r_go         <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_rom_we <= 1'b0;
      // Counter wraps to 0 on the 4th byte, which is also the only point a
      // byte-accepting state can change, so lanes restart cleanly per field.
      if (w_accept) begin
        r_asm      <= w_word[31:8];
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      case (r_state)
        HDR_PC: begin
          r_in_ready <= 1'b1;
          if (w_last_byte) begin
            r_start_pc <= w_word;
            r_state    <= HDR_LEN;
          end
        end
        HDR_LEN: begin
          if (w_last_byte) begin
            if (w_word == 32'd0) begin
              r_state    <= START;
              r_in_ready <= 1'b0;
            end else if (w_word > 32'(DEPTH)) begin
              r_state    <= ERR;
              r_error    <= 1'b1;
              r_in_ready <= 1'b0;
            end else begin
              r_len   <= w_word[ADDR_W:0];
              r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (w_last_byte) begin
            // N <= DEPTH, so the pre-increment count is always a valid address.
            r_rom_we     <= 1'b1;
            r_rom_wdata  <= w_word;
            r_rom_addr   <= r_word_count[ADDR_W-1:0];
            r_word_count <= w_count_nxt;
            if (w_count_nxt == r_len) begin
              r_state    <= START;
              r_in_ready <= 1'b0;
            end
          end
        end
        START: begin
          r_state <= RUN;
          r_go    <= 1'b1;
        end
        RUN: begin
          if (bus.halt) begin
            r_state <= DONE;
            r_go    <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE, ERR: begin
        end
        default: r_state <= HDR_PC;
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.rom_we     = r_rom_we;
  assign bus.rom_addr   = r_rom_addr;
  assign bus.rom_wdata  = r_rom_wdata;
  assign bus.start_pc   = r_start_pc;
  assign bus.go         = r_go;
  assign bus.done       = r_done;
  assign bus.error      = r_error;
  assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;

  logic clk;
  logic reset;

  rom_loader_if #(.ADDR_W(8)) ifc ();

  rom_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every ROM write must match the oldest expected write.
  always @(negedge clk) begin
    if (reset === 1'b1 && ifc.rom_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rom_we addr=0x%0h data=0x%0h", ifc.rom_addr, ifc.rom_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("rom_addr", {56'd0, ifc.rom_addr}, {56'd0, e.addr});
        chk("rom_wdata", {32'd0, ifc.rom_wdata}, {32'd0, e.data});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    @(negedge clk);
    if (gaps) begin
      ifc.in_valid = 1'b0;
      @(negedge clk);
    end
    ifc.in_valid = 1'b1;
    ifc.in_data  = b;
    n = 0;
    while (ifc.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout in_ready=%b required=1", ifc.in_ready);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
  endtask

  // Final byte was accepted at the last posedge: go must be 0 one cycle
  // later (START) and 1 the cycle after (RUN).
  task automatic go_timing(input string name);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    chk({name, "_go_plus1"}, {63'd0, ifc.go}, 64'd0);
    @(negedge clk);
    chk({name, "_go_plus2"}, {63'd0, ifc.go}, 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.halt     = 1'b0;
    reset        = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    ifc.halt     = 1'b0;
    #3;
    chk("rst_in_ready",   {63'd0, ifc.in_ready}, 64'd0);
    chk("rst_go",         {63'd0, ifc.go}, 64'd0);
    chk("rst_done",       {63'd0, ifc.done}, 64'd0);
    chk("rst_error",      {63'd0, ifc.error}, 64'd0);
    chk("rst_word_count", {55'd0, ifc.word_count}, 64'd0);
    chk("rst_start_pc",   {32'd0, ifc.start_pc}, 64'd0);
    chk("rst_rom_we",     {63'd0, ifc.rom_we}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", {63'd0, ifc.in_ready}, 64'd1);

    // Reference stream, continuous valid, then a one-cycle halt.
    exp_q.push_back('{8'd0, 32'h00100513});
    exp_q.push_back('{8'd1, 32'h00200593});
    send_word(32'h00001000, 1'b0);
    send_word(32'h00000002, 1'b0);
    send_word(32'h00100513, 1'b0);
    send_word(32'h00200593, 1'b0);
    go_timing("t1");
    chk("t1_start_pc",   {32'd0, ifc.start_pc}, 64'h1000);
    chk("t1_word_count", {55'd0, ifc.word_count}, 64'd2);
    chk("t1_in_ready",   {63'd0, ifc.in_ready}, 64'd0);
    ifc.halt = 1'b1;
    @(negedge clk);
    ifc.halt = 1'b0;
    chk("t1_halt_go",   {63'd0, ifc.go}, 64'd0);
    chk("t1_halt_done", {63'd0, ifc.done}, 64'd1);
    repeat (3) @(negedge clk);
    chk("t1_done_held", {62'd0, ifc.done, ifc.go}, 64'd2);

    // Same stream with gaps; halt held high across word 0 (LOAD) is ignored.
    do_reset();
    exp_q.push_back('{8'd0, 32'h00100513});
    exp_q.push_back('{8'd1, 32'h00200593});
    send_word(32'h00001000, 1'b1);
    send_word(32'h00000002, 1'b1);
    ifc.halt = 1'b1;
    send_word(32'h00100513, 1'b1);
    ifc.halt = 1'b0;
    send_word(32'h00200593, 1'b1);
    go_timing("t2");
    chk("t2_word_count", {55'd0, ifc.word_count}, 64'd2);
    chk("t2_start_pc",   {32'd0, ifc.start_pc}, 64'h1000);
    repeat (3) @(negedge clk);
    chk("t2_still_run", {62'd0, ifc.go, ifc.done}, 64'd2);

    // Length 0x101 exceeds DEPTH.
    do_reset();
    send_word(32'h00000040, 1'b0);
    send_word(32'h00000101, 1'b0);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    chk("t3_error",    {63'd0, ifc.error}, 64'd1);
    chk("t3_in_ready", {63'd0, ifc.in_ready}, 64'd0);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'hAA;
    ifc.halt     = 1'b1;
    repeat (5) @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.halt     = 1'b0;
    chk("t3_error_sticky", {63'd0, ifc.error}, 64'd1);
    chk("t3_go",           {63'd0, ifc.go}, 64'd0);
    chk("t3_word_count",   {55'd0, ifc.word_count}, 64'd0);

    // Length exactly DEPTH is accepted.
    do_reset();
    send_word(32'h00000040, 1'b0);
    send_word(32'h00000100, 1'b0);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    chk("t4_error",    {63'd0, ifc.error}, 64'd0);
    chk("t4_in_ready", {63'd0, ifc.in_ready}, 64'd1);

    // Length 0: straight to RUN.
    do_reset();
    send_word(32'h00000080, 1'b0);
    send_word(32'h00000000, 1'b0);
    go_timing("t5");
    chk("t5_word_count", {55'd0, ifc.word_count}, 64'd0);
    chk("t5_start_pc",   {32'd0, ifc.start_pc}, 64'h80);

    // Reset between edges in the middle of word 1, then a fresh stream.
    do_reset();
    exp_q.push_back('{8'd0, 32'h00100513});
    send_word(32'h00001000, 1'b0);
    send_word(32'h00000002, 1'b0);
    send_word(32'h00100513, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h05, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    ifc.in_valid = 1'b0;
    chk("t6_in_ready",   {63'd0, ifc.in_ready}, 64'd0);
    chk("t6_rom_wdata",  {32'd0, ifc.rom_wdata}, 64'd0);
    chk("t6_start_pc",   {32'd0, ifc.start_pc}, 64'd0);
    chk("t6_word_count", {55'd0, ifc.word_count}, 64'd0);
    chk("t6_rom_addr",   {56'd0, ifc.rom_addr}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back('{8'd0, 32'hDEADBEEF});
    send_word(32'h00002000, 1'b0);
    send_word(32'h00000001, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    go_timing("t6");
    chk("t6_new_word_count", {55'd0, ifc.word_count}, 64'd1);
    chk("t6_new_start_pc",   {32'd0, ifc.start_pc}, 64'h2000);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter: DEPTH, 256, instruction-ROM capacity in 32-bit words.
REQ-002 Parameter: ADDR_W, 8, width of rom_addr; DEPTH SHALL equal 2**ADDR_W.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  byte-stream source has a byte.
REQ-006 Port: in_data  input  8  byte-stream data.
REQ-007 Port: in_ready  output  1  loader can accept a byte.
REQ-008 Port: rom_we  output  1  instruction-ROM write strobe, one cycle per word.
REQ-009 Port: rom_addr  output  ADDR_W  ROM word index being written.
REQ-010 Port: rom_wdata  output  32  assembled instruction word.
REQ-011 Port: start_pc  output  32  boot PC for the CPU, from the stream header.
REQ-012 Port: go  output  1  CPU run enable; level signal.
REQ-013 Port: halt  input  1  CPU has finished execution.
REQ-014 Port: done  output  1  CPU halted after a run; level signal.
REQ-015 Port: error  output  1  stream header rejected; level signal.
REQ-016 Port: word_count  output  ADDR_W+1  number of words written so far.

Function
REQ-017 A byte SHALL be accepted only in a cycle with in_valid=1 and in_ready=1.
REQ-018 in_ready SHALL be 1 in states HDR_PC, HDR_LEN and LOAD, and 0 in all other states.
REQ-019 Stream format: 4 bytes start_pc, then 4 bytes length N, then N words of 4 bytes; all fields little-endian (first byte = bits 7:0).
REQ-020 States: HDR_PC, HDR_LEN, LOAD, START, RUN, DONE, ERR; reset state is HDR_PC.
REQ-021 A 2-bit byte counter SHALL select the byte lane; it wraps 3->0 on every 4th accepted byte and resets to 0 on each state change.
REQ-022 HDR_PC: on the 4th accepted byte, start_pc SHALL update and the state SHALL move to HDR_LEN.
REQ-023 HDR_LEN, 4th byte accepted: N=0 -> START; N>DEPTH -> ERR; otherwise -> LOAD.
REQ-024 LOAD: on the 4th byte of each word, the cycle after acceptance SHALL have rom_we=1, rom_wdata=the assembled word, rom_addr=word_count before increment; word_count SHALL increment in that same cycle.
REQ-025 LOAD: on acceptance of the final byte of word N-1, the state SHALL move to START.
REQ-026 START SHALL last exactly one cycle (it covers the final rom_we) and then move to RUN.
REQ-027 go SHALL be 1 only in RUN, so the first go=1 cycle is 2 cycles after the final byte is accepted.
REQ-028 RUN with halt=1 SHALL move to DONE; in DONE, go=0 and done=1.
REQ-029 halt SHALL be ignored in every state except RUN.
REQ-030 ERR: error=1, in_ready=0, go=0, and no rom_we; ERR and DONE are sticky until reset.
REQ-031 rom_we SHALL never be asserted for an address >= DEPTH.
REQ-032 in_valid=0 stalls SHALL not lose any partial-word state; bytes may arrive with arbitrary gaps.

Reset
REQ-033 When reset=0 (asynchronous, regardless of clk), outputs SHALL immediately be: in_ready=0, rom_we=0, rom_addr=0, rom_wdata=0, start_pc=0, go=0, done=0, error=0, word_count=0.
REQ-034 While reset=0, the state, byte counter and assembly register SHALL be cleared.
REQ-035 After reset deasserts, in_ready SHALL rise at the first rising clock edge.
REQ-036 Reset asserted mid-load SHALL abort the load; a complete new header is then required.
REQ-037 Reset SHALL not clear ROM contents.

Verification
REQ-038 Stream 00 10 00 00 | 02 00 00 00 | 13 05 10 00 | 93 05 20 00, continuous valid -> two rom_we pulses: addr 0 = 0x00100513, addr 1 = 0x00200593; start_pc=0x00001000; go=1 two cycles after the last byte; word_count=2.
REQ-039 Same stream with in_valid toggled every other cycle -> identical writes and go; no duplicated or dropped bytes.
REQ-040 Header length=0x00000101 with DEPTH=256 -> error=1, in_ready=0, no rom_we, go stays 0.
REQ-041 Header length=0 -> no rom_we; go=1 two cycles after the 8th byte.
REQ-042 In RUN, halt pulsed for 1 cycle -> go=0, done=1 next cycle and held; halt pulsed during LOAD -> no effect.
REQ-043 reset=0 asserted between clock edges after byte 2 of word 1 -> all outputs cleared at once; a full new stream loads correctly from addr 0.
